// File: rtl/hk_spi_master_pkg.sv
// Shared types and constants for the housekeeping SPI master.
// Optional abort support is enabled by defining HK_SPI_MASTER_ABORT_EN.
package hk_spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_BYTE_END,
        ST_WAIT_CMD,
        ST_CS_HOLD,
        ST_CS_IDLE
    } hk_state_e;

    localparam logic [7:0] HK_CMD_READ_STREAM  = 8'h40;
    localparam logic [7:0] HK_CMD_WRITE_STREAM = 8'h80;
    localparam logic [7:0] HK_CMD_PASS_THRU    = 8'hC4;
    localparam logic [7:0] HK_REG_PRODUCT_ID   = 8'h03;

    function automatic int unsigned hk_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hk_spi_sck_gen.sv
// Shared down-counter timing every FSM phase; strobes mark SCK rise/fall points.
// Used by hk_spi_master in all builds (HK_SPI_MASTER_ABORT_EN has no effect here).
module hk_spi_sck_gen #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             shift_lo,
    input  logic             shift_hi,
    output logic             tick_c,
    output logic             sck_rise_c,
    output logic             sck_fall_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c     = (cnt_q == '0);
    assign sck_rise_c = tick_c && shift_lo;
    assign sck_fall_c = tick_c && shift_hi;

endmodule

// File: rtl/hk_spi_master.sv
// Byte-stream mode-0 SPI master for the housekeeping SPI; CSB framing follows cmd_last.
// Define HK_SPI_MASTER_ABORT_EN to add the abort port that force-ends a frame.
module hk_spi_master
    import hk_spi_master_pkg::*;
#(
    parameter int unsigned SCK_HALF  = 4,
    parameter int unsigned CSB_SETUP = 2,
    parameter int unsigned CSB_HOLD  = 2,
    parameter int unsigned CSB_IDLE  = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_read,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_csb,
    output logic       spi_sdi,
`ifdef HK_SPI_MASTER_ABORT_EN
    input  logic       abort,
`endif
    input  logic       spi_sdo
);

    localparam int unsigned MAX_P = hk_max(hk_max(SCK_HALF, CSB_SETUP), hk_max(CSB_HOLD, CSB_IDLE));
    localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

    hk_state_e        state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             read_q, read_d;
    logic             last_q, last_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             csb_q, csb_d;
    logic             sdi_q, sdi_d;
    logic             accept_c;
    logic             load_c;
    logic [CNT_W-1:0] load_val_c;
    logic             tick_c, sck_rise_c, sck_fall_c;

    hk_spi_sck_gen #(.CNT_W(CNT_W)) u_sck_gen (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .load       (load_c),
        .load_val   (load_val_c),
        .shift_lo   (state_q == ST_SHIFT_LO),
        .shift_hi   (state_q == ST_SHIFT_HI),
        .tick_c     (tick_c),
        .sck_rise_c (sck_rise_c),
        .sck_fall_c (sck_fall_c)
    );

    assign accept_c = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        read_d     = read_q;
        last_d     = last_q;
        bit_d      = bit_q;
        rx_d       = rx_q;
        rsp_data_d = rsp_data_q;
        load_val_c = '0;

        case (state_q)
            ST_IDLE, ST_WAIT_CMD: begin
                if (accept_c) begin
                    data_d  = cmd_data;
                    read_d  = cmd_read;
                    last_d  = cmd_last;
                    bit_d   = 3'd7;
                    state_d = (state_q == ST_IDLE) ? ST_CS_SETUP : ST_SHIFT_LO;
                end
            end
            ST_CS_SETUP: if (tick_c) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: begin
                if (sck_rise_c) begin
                    rx_d    = {rx_q[6:0], spi_sdo};
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (sck_fall_c) begin
                    bit_d   = bit_q - 3'd1;
                    state_d = (bit_q == 3'd0) ? ST_BYTE_END : ST_SHIFT_LO;
                end
            end
            ST_BYTE_END: state_d = last_q ? ST_CS_HOLD : ST_WAIT_CMD;
            ST_CS_HOLD:  if (tick_c) state_d = ST_CS_IDLE;
            ST_CS_IDLE:  if (tick_c) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

`ifdef HK_SPI_MASTER_ABORT_EN
        // Abort drops the partial byte; hold/idle timing still applies so CSB framing stays clean.
        if (abort && !(state_q inside {ST_IDLE, ST_CS_IDLE, ST_CS_HOLD})) begin
            state_d = ST_CS_HOLD;
        end
`endif

        case (state_d)
            ST_CS_SETUP:              load_val_c = CNT_W'(CSB_SETUP - 1);
            ST_SHIFT_LO, ST_SHIFT_HI: load_val_c = CNT_W'(SCK_HALF - 1);
            ST_CS_HOLD:               load_val_c = CNT_W'(CSB_HOLD - 1);
            ST_CS_IDLE:               load_val_c = CNT_W'(CSB_IDLE - 1);
            default:                  load_val_c = '0;
        endcase
        load_c = (state_d != state_q);

        rsp_valid_d = (state_q == ST_SHIFT_HI) && (state_d == ST_BYTE_END) && read_q;
        if (rsp_valid_d) rsp_data_d = rx_q;

        sck_d       = (state_d == ST_SHIFT_HI);
        csb_d       = (state_d == ST_IDLE) || (state_d == ST_CS_IDLE);
        sdi_d       = (state_d inside {ST_SHIFT_LO, ST_SHIFT_HI}) ? data_d[bit_d] : 1'b0;
        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_CMD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            read_q      <= 1'b0;
            last_q      <= 1'b0;
            bit_q       <= 3'd7;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            sck_q       <= 1'b0;
            csb_q       <= 1'b1;
            sdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            read_q      <= read_d;
            last_q      <= last_d;
            bit_q       <= bit_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            sck_q       <= sck_d;
            csb_q       <= csb_d;
            sdi_q       <= sdi_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign spi_sck   = sck_q;
    assign spi_csb   = csb_q;
    assign spi_sdi   = sdi_q;

endmodule
